// File: rtl/pipe_scoreboard.sv
// rtl/pipe_scoreboard.sv - in-order pipeline register scoreboard with forwarding select and load-use stall
// Tracks destination registers of in-flight instructions and steers ID operands to the youngest producer.
module pipe_scoreboard #(
  parameter int NREG       = 16,
  parameter int AW         = 4,
  parameter int DEPTH      = 3,
  parameter int LATE_STAGE = 2,
  parameter int FLUSH_N    = 2,
  parameter int ZERO_R0    = 1,
  localparam int SW        = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            id_valid_i,
  input  logic [AW-1:0]   id_rs0_i,
  input  logic [AW-1:0]   id_rs1_i,
  input  logic            id_rs0_en_i,
  input  logic            id_rs1_en_i,
  input  logic [AW-1:0]   id_rd_i,
  input  logic            id_we_i,
  input  logic            id_late_i,
  input  logic            hold_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            issue_o,
  output logic [SW-1:0]   fwd0_sel_o,
  output logic [SW-1:0]   fwd1_sel_o,
  output logic [NREG-1:0] pend_mask_o,
  output logic [SW-1:0]   inflight_o
);

  // Index k-1 holds stage k; index 0 is the youngest (EX) stage.
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][AW-1:0] rd_q, rd_d;
  logic [DEPTH-1:0]         late_q, late_d;

  logic [1:0][AW-1:0] src;
  logic [1:0]         src_en;
  logic [1:0][SW-1:0] sel;
  logic [1:0]         sel_late;
  logic [1:0]         src_blocked;

  assign src    = {id_rs1_i, id_rs0_i};
  assign src_en = {id_rs1_en_i, id_rs0_en_i};

  // Scan oldest to youngest so the youngest matching stage overwrites older ones.
  always_comb begin
    sel      = '0;
    sel_late = '0;
    for (int j = 0; j < 2; j++) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (src_en[j] && valid_q[k-1] && (rd_q[k-1] == src[j]) &&
            !((ZERO_R0 != 0) && (src[j] == '0))) begin
          sel[j]      = SW'(k);
          sel_late[j] = late_q[k-1];
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < 2; j++) begin
      src_blocked[j] = sel_late[j] && (int'(sel[j]) < LATE_STAGE);
    end
  end

  assign stall_o    = id_valid_i && (|src_blocked);
  assign issue_o    = id_valid_i && !stall_o && !hold_i && !flush_i;
  assign fwd0_sel_o = stall_o ? '0 : sel[0];
  assign fwd1_sel_o = stall_o ? '0 : sel[1];

  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    late_d  = late_q;
    if (!hold_i) begin
      valid_d[0] = issue_o && id_we_i && !((ZERO_R0 != 0) && (id_rd_i == '0));
      rd_d[0]    = id_rd_i;
      late_d[0]  = id_late_i;
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        rd_d[k]    = rd_q[k-1];
        late_d[k]  = late_q[k-1];
      end
    end
    // Flush kills the youngest stages whether or not the pipe advances.
    if (flush_i) begin
      for (int k = 0; k < FLUSH_N; k++) begin
        valid_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      rd_q    <= '0;
      late_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      late_q  <= late_d;
    end
  end

  always_comb begin
    pend_mask_o = '0;
    inflight_o  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[k] && (int'(rd_q[k]) < NREG)) begin
        pend_mask_o[rd_q[k]] = 1'b1;
      end
      inflight_o = inflight_o + SW'(valid_q[k]);
    end
  end

endmodule

// File: doc/pipe_scoreboard.md
PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 SHALL provide parameter NREG, default 16, number of architectural registers.
REQ-002 SHALL provide parameter AW, default 4, register-address width, with NREG <= 2^AW.
REQ-003 SHALL provide parameter DEPTH, default 3, number of tracked stages from issue to retire (stage 1 = youngest, EX).
REQ-004 SHALL provide parameter LATE_STAGE, default 2, first stage at which a late (load) result is forwardable.
REQ-005 SHALL provide parameter FLUSH_N, default 2, number of youngest stages killed by flush (1..DEPTH).
REQ-006 SHALL provide parameter ZERO_R0, default 1; when 1, register 0 is never tracked and never hazards.
REQ-007 SHALL define SW = clog2(DEPTH+1) as a derived width.
REQ-008 clk  input  1  single clock; all state updates on posedge.
REQ-009 rst  input  1  asynchronous, active-low reset.
REQ-010 id_valid  input  1  ID stage holds a valid instruction.
REQ-011 id_rs0, id_rs1  input  AW each  source register addresses.
REQ-012 id_rs0_en, id_rs1_en  input  1 each  source actually read.
REQ-013 id_rd  input  AW  destination register; id_we  input  1  instruction writes id_rd.
REQ-014 id_late  input  1  result available only from LATE_STAGE onward.
REQ-015 hold  input  1  freeze: no stage advances.
REQ-016 flush  input  1  kill the youngest FLUSH_N stages (taken branch/jump).
REQ-017 stall  output  1  RAW hazard not resolvable by forwarding.
REQ-018 issue  output  1  ID instruction enters stage 1 this edge.
REQ-019 fwd0_sel, fwd1_sel  output  SW each  0 = register file, k = forward from stage k.
REQ-020 pend_mask  output  NREG  bit r set when any valid in-flight entry writes r.
REQ-021 inflight  output  SW  count of valid entries.

Function
REQ-022 SHALL hold per stage k an entry {valid, rd, late}; valid only if the writing instruction had id_we=1 (and id_rd!=0 when ZERO_R0=1).
REQ-023 Match: source s enabled, stage k valid, rd==s, and not (ZERO_R0 and s==0).
REQ-024 For each source, the youngest (lowest k) matching stage SHALL be selected; older matches are ignored.
REQ-025 stall SHALL be 1 when id_valid and some source's selected entry has late=1 and k<LATE_STAGE.
REQ-026 fwdN_sel SHALL equal the selected k, or 0 when no match or when stall=1.
REQ-027 issue = id_valid & ~stall & ~hold & ~flush, combinational.
REQ-028 On posedge, hold=0, flush=0: stage1 <= issue ? {1,id_rd,id_late} : bubble; stage k <= stage k-1 for k>=2; stage DEPTH contents retire.
REQ-029 On posedge, flush=1, hold=0: shift as REQ-028, but stages 1..FLUSH_N SHALL be invalid afterwards; stages > FLUSH_N take shifted values.
REQ-030 On posedge, hold=1, flush=0: all stages unchanged.
REQ-031 On posedge, hold=1, flush=1: no shift; stages 1..FLUSH_N invalidated in place.
REQ-032 pend_mask and inflight SHALL be combinational from current stage contents; zero latency.
REQ-033 Stall SHALL insert exactly one bubble per stalled cycle; stall persists until the late entry reaches LATE_STAGE.

Reset
REQ-034 rst=0 SHALL immediately invalidate all stages: stall=0, issue=id_valid&~hold&~flush, fwd sels=0, pend_mask=0, inflight=0.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight entries with no retire effect.

Verification (DEPTH=3, LATE_STAGE=2, FLUSH_N=2, ZERO_R0=1)
REQ-036 Three writers in flight, rst low between edges -> pend_mask=0, inflight=0 before next edge.
REQ-037 ALU write r3 issued, then read r3 each cycle -> fwd0_sel 1,2,3, then 0; stall=0 throughout.
REQ-038 Load to r5, next instruction reads r5 on rs1 -> stall=1, issue=0 for one cycle; next cycle fwd1_sel=2, stall=0.
REQ-039 Writes to r2 in stages 2 and 1, read r2 -> fwd0_sel=1.
REQ-040 Entries in stages 1,2,3 plus flush -> after edge only stage 3 valid (old stage 2), inflight=1.
REQ-041 hold=1 for 2 cycles -> pend_mask unchanged, issue=0; read/write of r0 -> no stall, fwd sel 0, pend_mask[0]=0.
